// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: opcodes, functs,
// state encoding, datapath select codes and the registered control word.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_EXCEPT   = 4'd13,
    S_LOAD     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_SYS = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       exception;
  } ctrl_t;

  // Moore control word for a state. The fetch-completion strobes
  // (IR load, PC+4 load) are added in the top, qualified by the handshake.
  function automatic ctrl_t ctrl_word(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM2;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNC;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a    = 1'b1;
        c.alu_src_b    = SRCB_RT;
        c.alu_op       = ALU_SUB;
        c.pc_write_beq = 1'b1;
        c.pc_src       = PC_BR;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JMP;
      end
      S_EXCEPT: c.exception = 1'b1;
      S_LOAD: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_SYS;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = sequencer, slave = datapath/debug side.
interface multicycle_ctrl_if #(
  parameter int CNT_W     = 16,
  parameter int EXC_CNT_W = 8
);
  logic                 SYS_load;
  logic [5:0]           opcode;
  logic [5:0]           func;
  logic                 alu_zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_beq;
  logic [1:0]           pc_src;
  logic                 ir_write;
  logic                 i_or_d;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_to_reg;
  logic                 reg_dst;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic                 exception;
  logic [3:0]           state_q;
  logic [CNT_W-1:0]     instr_cnt;
  logic [EXC_CNT_W-1:0] exc_cnt;

  modport master (
    input  SYS_load, opcode, func, alu_zero, mem_ready,
    output pc_write, pc_write_beq, pc_src, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           exception, state_q, instr_cnt, exc_cnt
  );

  modport slave (
    output SYS_load, opcode, func, alu_zero, mem_ready,
    input  pc_write, pc_write_beq, pc_src, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           exception, state_q, instr_cnt, exc_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Instruction classifier used in DECODE: picks the next state from
// opcode/funct and flags anything the datapath cannot execute.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output state_t     next,
  output logic       illegal
);

  // Opcode table; an R-type with an unsupported funct is treated as illegal.
  always_comb begin
    next = S_EXCEPT;
    case (opcode)
      OP_RTYPE: if (func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) next = S_EXEC_R;
      OP_LW, OP_SW: next = S_MEM_ADDR;
      OP_BEQ:  next = S_BRANCH;
      OP_J:    next = S_JUMP;
      OP_ADDI: next = S_EXEC_I;
      default: next = S_EXCEPT;
    endcase
    illegal = (next == S_EXCEPT);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, registered
// control word and the retired-instruction / exception counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int EXC_CNT_W = 8
) (
  input logic               SYS_clk,
  input logic               SYS_reset,
  multicycle_ctrl_if.master bus
);

  state_t               state_q, state_d;
  state_t               dec_next;
  logic                 dec_illegal;
  logic                 known;
  ctrl_t                ctrl_q;
  logic                 fetch_done;
  logic                 retire;
  logic [CNT_W-1:0]     instr_cnt;
  logic [EXC_CNT_W-1:0] exc_cnt;

  multicycle_ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .func    (bus.func),
    .next    (dec_next),
    .illegal (dec_illegal)
  );

  // Next state; a load request preempts everything except a write still in flight.
  always_comb begin
    state_d = S_IDLE;
    known   = 1'b1;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = dec_illegal ? S_EXCEPT : dec_next;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_EXCEPT, S_LOAD:
                  state_d = S_FETCH;
      default: begin
        state_d = S_IDLE;
        known   = 1'b0;
      end
    endcase
    if (known && bus.SYS_load && (state_q != S_MEM_WR || bus.mem_ready))
      state_d = S_LOAD;
  end

  // State and control word registered together so outputs never glitch.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_word(state_d);
    end
  end

  // IR and PC+4 load only on the fetch cycle the memory completes, unless a
  // simultaneous load request abandons the fetch.
  assign fetch_done = (state_q == S_FETCH) && bus.mem_ready && !bus.SYS_load;

  // An instruction retires on the edge leaving its final state.
  assign retire = (state_q inside {S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP}) ||
                  (state_q == S_MEM_WR && bus.mem_ready);

  // Retired count wraps; exception count sticks at all-ones.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      instr_cnt <= '0;
      exc_cnt   <= '0;
    end else begin
      if (retire) instr_cnt <= instr_cnt + 1'b1;
      if (state_q == S_EXCEPT && exc_cnt != '1) exc_cnt <= exc_cnt + 1'b1;
    end
  end

  assign bus.pc_write     = ctrl_q.pc_write | fetch_done;
  assign bus.ir_write     = fetch_done;
  assign bus.pc_write_beq = ctrl_q.pc_write_beq;
  assign bus.pc_src       = ctrl_q.pc_src;
  assign bus.i_or_d       = ctrl_q.i_or_d;
  assign bus.mem_read     = ctrl_q.mem_read;
  assign bus.mem_write    = ctrl_q.mem_write;
  assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.reg_dst      = ctrl_q.reg_dst;
  assign bus.reg_write    = ctrl_q.reg_write;
  assign bus.alu_src_a    = ctrl_q.alu_src_a;
  assign bus.alu_src_b    = ctrl_q.alu_src_b;
  assign bus.alu_op       = ctrl_q.alu_op;
  assign bus.exception    = ctrl_q.exception;
  assign bus.state_q      = state_q;
  assign bus.instr_cnt    = instr_cnt;
  assign bus.exc_cnt      = exc_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state paths and control words
// built from the instruction class, counters tracked as plain integers.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic gclk = 1'b0;
  logic rst  = 1'b1;

  multicycle_ctrl_if #(.CNT_W(16), .EXC_CNT_W(8)) bus ();
  multicycle_ctrl #(.CNT_W(16), .EXC_CNT_W(8)) dut (
    .SYS_clk   (gclk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    state_t st;
    bit     rdy;
    bit     ld;
  } step_t;

  step_t plan[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    m_instr = 0;
  int    m_exc   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal_fn(logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  function automatic bit legal_op(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  // Expected control outputs for one observed cycle.
  function automatic logic [16:0] want_word(state_t st, bit rdy, bit ld);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01;
                        c.ir_write = rdy & ~ld; c.pc_write = rdy & ~ld; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_WB_R:     begin c.reg_dst = 1; c.reg_write = 1; end
      S_EXEC_I:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_WB_I:     c.reg_write = 1;
      S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
      S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
      S_WB_MEM:   begin c.reg_write = 1; c.mem_to_reg = 1; end
      S_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_beq = 1; c.pc_src = 2'b01; end
      S_JUMP:     begin c.pc_write = 1; c.pc_src = 2'b10; end
      S_EXCEPT:   c.exception = 1;
      S_LOAD:     begin c.pc_write = 1; c.pc_src = 2'b11; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [16:0] seen_word();
    ctrl_t c;
    c.pc_write     = bus.pc_write;
    c.pc_write_beq = bus.pc_write_beq;
    c.pc_src       = bus.pc_src;
    c.ir_write     = bus.ir_write;
    c.i_or_d       = bus.i_or_d;
    c.mem_read     = bus.mem_read;
    c.mem_write    = bus.mem_write;
    c.mem_to_reg   = bus.mem_to_reg;
    c.reg_dst      = bus.reg_dst;
    c.reg_write    = bus.reg_write;
    c.alu_src_a    = bus.alu_src_a;
    c.alu_src_b    = bus.alu_src_b;
    c.alu_op       = bus.alu_op;
    c.exception    = bus.exception;
    return c;
  endfunction

  task automatic add(state_t st, bit rdy, bit ld);
    step_t s;
    s.st = st; s.rdy = rdy; s.ld = ld;
    plan.push_back(s);
  endtask

  task automatic add_fetch(int fw);
    for (int i = 0; i < fw; i++) add(S_FETCH, 1'b0, 1'b0);
    add(S_FETCH, 1'b1, 1'b0);
  endtask

  task automatic add_load(int k);
    for (int i = 0; i < k; i++) add(S_LOAD, rnd(), 1'b1);
    add(S_LOAD, rnd(), 1'b0);
  endtask

  // Drives one planned cycle per negedge and checks state and outputs.
  task automatic run_plan(logic [5:0] op, logic [5:0] fn, int az);
    foreach (plan[i]) begin
      @(negedge gclk);
      if (i == 0) begin
        bus.opcode = op;
        bus.func   = fn;
      end
      bus.mem_ready = plan[i].rdy;
      bus.SYS_load  = plan[i].ld;
      bus.alu_zero  = (az < 0) ? rnd() : az[0];
      #1;
      if (i == 0) begin
        chk("instr_cnt", 32'(bus.instr_cnt), 32'(m_instr));
        chk("exc_cnt", 32'(bus.exc_cnt), 32'(m_exc));
      end
      chk($sformatf("state[%0d] op=%0h", i, op), 32'(bus.state_q), 32'(plan[i].st));
      chk($sformatf("ctrl[%0d] op=%0h st=%0d", i, op, plan[i].st), 32'(seen_word()),
          32'(want_word(plan[i].st, plan[i].rdy, plan[i].ld)));
    end
    plan.delete();
  endtask

  task automatic retire_one();
    m_instr = (m_instr + 1) & 16'hFFFF;
  endtask

  // One complete instruction from FETCH, with fw fetch and mw data wait cycles.
  task automatic do_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, int az);
    bit bad;
    bad = 1'b0;
    add_fetch(fw);
    add(S_DECODE, rnd(), 1'b0);
    if (op == OP_RTYPE && legal_fn(fn)) begin
      add(S_EXEC_R, rnd(), 1'b0); add(S_WB_R, rnd(), 1'b0);
    end else if (op == OP_ADDI) begin
      add(S_EXEC_I, rnd(), 1'b0); add(S_WB_I, rnd(), 1'b0);
    end else if (op == OP_LW) begin
      add(S_MEM_ADDR, rnd(), 1'b0);
      for (int i = 0; i < mw; i++) add(S_MEM_RD, 1'b0, 1'b0);
      add(S_MEM_RD, 1'b1, 1'b0);
      add(S_WB_MEM, rnd(), 1'b0);
    end else if (op == OP_SW) begin
      add(S_MEM_ADDR, rnd(), 1'b0);
      for (int i = 0; i < mw; i++) add(S_MEM_WR, 1'b0, 1'b0);
      add(S_MEM_WR, 1'b1, 1'b0);
    end else if (op == OP_BEQ) begin
      add(S_BRANCH, rnd(), 1'b0);
    end else if (op == OP_J) begin
      add(S_JUMP, rnd(), 1'b0);
    end else begin
      add(S_EXCEPT, rnd(), 1'b0);
      bad = 1'b1;
    end
    run_plan(op, fn, az);
    if (bad) begin
      if (m_exc < 255) m_exc++;
    end else begin
      retire_one();
    end
  endtask

  // Load request during a fetch (with or without ready): fetch abandoned.
  task automatic abandon_fetch(int fw, int k);
    for (int i = 0; i < fw; i++) add(S_FETCH, 1'b0, 1'b0);
    add(S_FETCH, rnd(), 1'b1);
    add_load(k);
    run_plan(OP_ADDI, 6'h00, -1);
  endtask

  // Load request in MEM_RD: the lw is abandoned and never counted.
  task automatic abandon_lw(int mw, int k);
    add_fetch(0);
    add(S_DECODE, rnd(), 1'b0);
    add(S_MEM_ADDR, rnd(), 1'b0);
    for (int i = 0; i < mw; i++) add(S_MEM_RD, 1'b0, 1'b0);
    add(S_MEM_RD, rnd(), 1'b1);
    add_load(k);
    run_plan(OP_LW, 6'h00, -1);
  endtask

  // Load request held across a pending write: write completes, then LOAD.
  task automatic sw_then_load(int mw, int k);
    add_fetch(0);
    add(S_DECODE, rnd(), 1'b0);
    add(S_MEM_ADDR, rnd(), 1'b0);
    for (int i = 0; i < mw; i++) add(S_MEM_WR, 1'b0, 1'b1);
    add(S_MEM_WR, 1'b1, 1'b1);
    add_load(k);
    run_plan(OP_SW, 6'h00, -1);
    retire_one();
  endtask

  // Asynchronous reset while a lw waits in MEM_RD.
  task automatic reset_in_mem_rd();
    add_fetch(0);
    add(S_DECODE, rnd(), 1'b0);
    add(S_MEM_ADDR, rnd(), 1'b0);
    run_plan(OP_LW, 6'h00, -1);
    @(negedge gclk);
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_pre_state", 32'(bus.state_q), 32'(S_MEM_RD));
    chk("rst_pre_mem_read", 32'(bus.mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state_q), 32'(S_IDLE));
    chk("rst_ctrl", 32'(seen_word()), 32'd0);
    chk("rst_instr_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("rst_exc_cnt", 32'(bus.exc_cnt), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge gclk);
    #1;
    chk("rst_hold_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_hold_state", 32'(bus.state_q), 32'(S_IDLE));
    rst = 1'b0;
    m_instr = 0;
    m_exc   = 0;
  endtask

  function automatic logic [5:0] bad_op();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63)); while (legal_op(op));
    return op;
  endfunction

  initial begin
    logic [5:0] op, fn;
    int         sel;
    bus.SYS_load  = 1'b0;
    bus.opcode    = 6'h00;
    bus.func      = 6'h00;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    rst           = 1'b1;

    repeat (2) @(negedge gclk);
    #1;
    chk("reset_state", 32'(bus.state_q), 32'(S_IDLE));
    chk("reset_ctrl", 32'(seen_word()), 32'd0);
    chk("reset_instr_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("reset_exc_cnt", 32'(bus.exc_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_after_reset", 32'(bus.state_q), 32'(S_IDLE));

    // Directed cases.
    do_instr(OP_ADDI, 6'h00, 0, 0, -1);
    do_instr(OP_RTYPE, FN_ADD, 0, 0, -1);
    do_instr(OP_LW, 6'h00, 0, 3, -1);
    do_instr(OP_BEQ, 6'h00, 0, 0, 1);
    do_instr(OP_BEQ, 6'h00, 0, 0, 0);
    do_instr(6'b111111, 6'h00, 0, 0, -1);
    do_instr(OP_RTYPE, 6'h3F, 1, 0, -1);
    do_instr(OP_J, 6'h00, 2, 0, -1);
    do_instr(OP_SW, 6'h00, 0, 2, -1);
    sw_then_load(3, 2);
    abandon_fetch(2, 1);
    abandon_lw(1, 2);
    do_instr(OP_RTYPE, FN_SLT, 0, 0, -1);
    reset_in_mem_rd();

    // Randomised instruction mix with occasional load preemption.
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 11);
      fn  = 6'($urandom_range(0, 63));
      case (sel)
        0, 1: begin
          fn = (rnd()) ? FN_SUB : FN_OR;
          do_instr(OP_RTYPE, fn, $urandom_range(0, 2), 0, -1);
        end
        2: do_instr(OP_ADDI, fn, $urandom_range(0, 2), 0, -1);
        3: do_instr(OP_LW, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        4: do_instr(OP_SW, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        5: do_instr(OP_BEQ, fn, $urandom_range(0, 2), 0, -1);
        6: do_instr(OP_J, fn, $urandom_range(0, 2), 0, -1);
        7: do_instr(OP_RTYPE, fn, 0, 0, -1);
        8: do_instr(bad_op(), fn, $urandom_range(0, 1), 0, -1);
        9: abandon_fetch($urandom_range(0, 2), $urandom_range(0, 3));
        10: abandon_lw($urandom_range(0, 2), $urandom_range(0, 2));
        default: sw_then_load($urandom_range(0, 3), $urandom_range(0, 2));
      endcase
    end

    // Enough illegal instructions to pin the exception counter.
    for (int n = 0; n < 300; n++) begin
      op = (rnd()) ? bad_op() : OP_RTYPE;
      fn = 6'h3F;
      do_instr(op, fn, 0, 0, -1);
    end

    @(negedge gclk);
    bus.mem_ready = 1'b0;
    #1;
    chk("final_state", 32'(bus.state_q), 32'(S_FETCH));
    chk("final_instr_cnt", 32'(bus.instr_cnt), 32'(m_instr));
    chk("final_exc_sat", 32'(bus.exc_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
